mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller for the 5-stage 64-bit pipelined CPU, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs and drives a variable-latency data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and contains the MEM/WB pipeline register that feeds write-back. It also detects misaligned accesses and memory timeouts.

## Interface
Parameters:
- TIMEOUT_CYC, 255: maximum BUSY cycles waiting for dmem_ack before a bus error is declared (1..255; counter is 8 bits).

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- memWrite_E_MEM  in  1  store enable from EX/MEM
- mem_read_MEM  in  1  load enable from EX/MEM
- MemToReg_MEM  in  1  write-back source select: 1 = memory data, 0 = ALU result
- regWrite_E_MEM  in  1  register-file write enable from EX/MEM
- ALU_out_MEM  in  64  ALU result; used as memory address and as write-back data
- regWrite_MEM  in  5  destination register number
- mem_Din_MEM  in  64  store data
- dmem_req  out  1  registered memory request
- dmem_we  out  1  registered; 1 = write
- dmem_addr  out  64  registered address
- dmem_wdata  out  64  registered store data
- dmem_ack  in  1  memory completion; sampled only in BUSY
- dmem_rdata  in  64  load data, valid in the cycle dmem_ack is high
- stall_MEM  out  1  combinational; 1 holds PC, IF/ID, ID/EX and EX/MEM
- regWrite_E_WB  out  1  MEM/WB write enable
- regWrite_WB  out  5  MEM/WB destination register
- wb_data_WB  out  64  MEM/WB write-back data
- misalign_err  out  1  sticky; set on a misaligned access
- bus_err  out  1  sticky; set on a timeout

## Operation
- Definitions:
  - access = mem_read_MEM | memWrite_E_MEM.
  - misaligned = access & (ALU_out_MEM[2:0] != 0).
  - If read and write are both asserted, the access is treated as a write and its write-back is suppressed.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Access that is not misaligned: stall_MEM=1. Register dmem_req=1, dmem_we=memWrite_E_MEM, dmem_addr=ALU_out_MEM, dmem_wdata=mem_Din_MEM. Clear the timeout counter. Go to BUSY.
  - Misaligned access: no request and no stall. Set misalign_err. MEM/WB loads a bubble (regWrite_E_WB=0). Stay in IDLE.
  - No access: no stall. MEM/WB loads {regWrite_E_MEM, regWrite_MEM, ALU_out_MEM}.
- BUSY: stall_MEM=1; dmem_* outputs held stable; counter increments each cycle.
  - dmem_ack=1: capture dmem_rdata, drop dmem_req, go to DONE.
  - No ack when the counter reaches TIMEOUT_CYC: drop dmem_req, set bus_err, mark the instruction as killed, go to DONE.
- DONE: stall_MEM=0; return to IDLE unconditionally. MEM/WB loads:
  - regWrite_MEM, and
  - wb_data = captured rdata if MemToReg_MEM, else ALU_out_MEM, and
  - regWrite_E_WB = regWrite_E_MEM & ~killed & ~(read & write).
- MEM/WB loads a bubble (regWrite_E_WB=0; regWrite_WB and wb_data_WB hold their previous values) on every edge where stall_MEM=1.
- dmem_ack outside BUSY is ignored.
- Error flags are sticky; only reset clears them.

## Timing
- Reset values (asynchronous): state=IDLE, every registered output = 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, regWrite_E_WB, regWrite_WB, wb_data_WB, misalign_err, bus_err), counter=0, killed=0. stall_MEM is combinational and therefore 0 in IDLE with no access.
- Reset mid-access: the request is abandoned immediately and nothing is written back.
- Non-memory instruction: 0 stall cycles; visible on the WB outputs one edge after it is presented.
- Memory access with ack after k BUSY cycles (k ≥ 1): stall_MEM high for k+1 cycles (the IDLE arrival cycle plus k BUSY cycles); WB outputs valid at the edge ending the DONE cycle.
- Minimum memory-access latency: 3 cycles in MEM.
- Timeout: TIMEOUT_CYC BUSY cycles, then DONE.
- EX/MEM inputs are stable while stall_MEM=1; the block relies on this.

## Structure
- Package mem_stage_pkg holds:
  - the state enum typedef {IDLE, BUSY, DONE},
  - localparam WORD_ALIGN_MASK = 3'b111,
  - localparam REG_W = 5 and DATA_W = 64.
- Sub-module mem_wb_reg: the MEM/WB pipeline register, built from the existing register and D_FF cells with the same clk/reset ports. It loads the bubble or the payload as selected by the controller.

## Test plan
- ALU op, ALU_out=0x1234, regWrite=5, regWrite_E=1 -> stall_MEM=0; next edge regWrite_WB=5, wb_data_WB=0x1234, regWrite_E_WB=1.
- Load from 0x40, ack on the 3rd BUSY cycle with rdata=0xDEADBEEF, MemToReg=1 -> stall_MEM high 4 cycles; dmem_addr=0x40 and dmem_we=0 held throughout; then wb_data_WB=0xDEADBEEF with regWrite_E_WB=1.
- Store to 0x88, data 0xAA, ack on the 1st BUSY cycle -> dmem_we=1, dmem_wdata=0xAA; 2 stall cycles; regWrite_E_WB=0.
- Load from 0x43 -> no dmem_req, stall_MEM=0, misalign_err=1 and sticky, regWrite_E_WB=0.
- TIMEOUT_CYC=4, load never acked -> dmem_req drops after 4 BUSY cycles, bus_err=1, write-back suppressed, pipeline resumes.
- Assert reset in the 2nd BUSY cycle -> dmem_req=0, state IDLE, all outputs 0 immediately; an ack arriving afterwards is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller and its MEM/WB register.
package mem_stage_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 8;

    localparam logic [2:0] WORD_ALIGN_MASK = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Payload loaded into MEM/WB when the controller lets an instruction retire.
    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_payload_t;

    // A 64-bit access must sit on an 8-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] addr_lo);
        return |(addr_lo & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: loads the payload or a bubble (write enable cleared, rest held).
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  wb_payload_t       payload_i,
    output logic              we_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [DATA_W-1:0] data_o
);

    logic              we_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] data_q;

    // Payload on load, otherwise a bubble that only kills the write enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (load_i) begin
            we_q   <= payload_i.we;
            rd_q   <= payload_i.rd;
            data_q <= payload_i.data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    assign we_o   = we_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data-memory handshake, stalls upstream
// while an access is outstanding, flags misalignment/timeouts and feeds MEM/WB.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memWrite_E_MEM,
    input  logic              mem_read_MEM,
    input  logic              MemToReg_MEM,
    input  logic              regWrite_E_MEM,
    input  logic [DATA_W-1:0] ALU_out_MEM,
    input  logic [REG_W-1:0]  regWrite_MEM,
    input  logic [DATA_W-1:0] mem_Din_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_MEM,
    output logic              regWrite_E_WB,
    output logic [REG_W-1:0]  regWrite_WB,
    output logic [DATA_W-1:0] wb_data_WB,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              killed_q, killed_d;
    logic              mis_q, mis_d;
    logic              bus_q, bus_d;

    logic              access;
    logic              misaligned;
    logic              rw_both;
    logic              wb_load;
    wb_payload_t       wb_payload;

    assign access     = mem_read_MEM | memWrite_E_MEM;
    assign misaligned = access & is_misaligned(ALU_out_MEM[2:0]);
    assign rw_both    = mem_read_MEM & memWrite_E_MEM;

    // State and registered bus/flag outputs; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            killed_q <= 1'b0;
            mis_q    <= 1'b0;
            bus_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            killed_q <= killed_d;
            mis_q    <= mis_d;
            bus_q    <= bus_d;
        end
    end

    // Next-state, stall and MEM/WB load selection.
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        cnt_d           = cnt_q;
        killed_d        = killed_q;
        mis_d           = mis_q;
        bus_d           = bus_q;
        stall_MEM       = 1'b0;
        wb_load         = 1'b0;
        wb_payload.we   = 1'b0;
        wb_payload.rd   = regWrite_MEM;
        wb_payload.data = ALU_out_MEM;

        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    mis_d = 1'b1;
                end else if (access) begin
                    stall_MEM = 1'b1;
                    req_d     = 1'b1;
                    we_d      = memWrite_E_MEM;
                    addr_d    = ALU_out_MEM;
                    wdata_d   = mem_Din_MEM;
                    cnt_d     = '0;
                    killed_d  = 1'b0;
                    state_d   = BUSY;
                end else begin
                    wb_load       = 1'b1;
                    wb_payload.we = regWrite_E_MEM;
                end
            end
            BUSY: begin
                stall_MEM = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d    = 1'b0;
                    bus_d    = 1'b1;
                    killed_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                wb_load         = 1'b1;
                wb_payload.we   = regWrite_E_MEM & ~killed_q & ~rw_both;
                wb_payload.data = MemToReg_MEM ? rdata_q : ALU_out_MEM;
                killed_d        = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (wb_load),
        .payload_i (wb_payload),
        .we_o      (regWrite_E_WB),
        .rd_o      (regWrite_WB),
        .data_o    (wb_data_WB)
    );

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign misalign_err = mis_q;
    assign bus_err      = bus_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected write-back results are queued
// when an instruction is presented and compared when it leaves the stage.
module tb_mem_stage_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memWrite_E_MEM;
    logic        mem_read_MEM;
    logic        MemToReg_MEM;
    logic        regWrite_E_MEM;
    logic [63:0] ALU_out_MEM;
    logic [4:0]  regWrite_MEM;
    logic [63:0] mem_Din_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        stall_MEM;
    logic        regWrite_E_WB;
    logic [4:0]  regWrite_WB;
    logic [63:0] wb_data_WB;
    logic        misalign_err;
    logic        bus_err;

    mem_stage_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .memWrite_E_MEM (memWrite_E_MEM),
        .mem_read_MEM   (mem_read_MEM),
        .MemToReg_MEM   (MemToReg_MEM),
        .regWrite_E_MEM (regWrite_E_MEM),
        .ALU_out_MEM    (ALU_out_MEM),
        .regWrite_MEM   (regWrite_MEM),
        .mem_Din_MEM    (mem_Din_MEM),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .stall_MEM      (stall_MEM),
        .regWrite_E_WB  (regWrite_E_WB),
        .regWrite_WB    (regWrite_WB),
        .wb_data_WB     (wb_data_WB),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_mis  = 1'b0;
    logic exp_bus  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_nop();
        mem_read_MEM   = 1'b0;
        memWrite_E_MEM = 1'b0;
        MemToReg_MEM   = 1'b0;
        regWrite_E_MEM = 1'b0;
        ALU_out_MEM    = 64'd0;
        regWrite_MEM   = 5'd0;
        mem_Din_MEM    = 64'd0;
    endtask

    // Present one instruction, hold it while stalled, answer the memory and check it retires.
    // ack_at: BUSY cycle (1-based) carrying dmem_ack; 0 = never.
    task automatic run_instr(input string tag, input logic r, input logic w, input logic m2r,
                             input logic rwe, input logic [63:0] addr, input logic [4:0] rd,
                             input logic [63:0] din, input int ack_at, input logic [63:0] rdata);
        logic acc;
        logic mis;
        logic killed;
        logic stl;
        bit   done;
        int   k;
        int   exp_stall;
        int   n_stall;
        exp_t e;

        acc       = r | w;
        mis       = acc && (addr[2:0] != 3'd0);
        killed    = 1'b0;
        k         = 0;
        exp_stall = 0;
        if (acc && !mis) begin
            if (ack_at >= 1 && ack_at <= int'(TO)) begin
                k = ack_at;
            end else begin
                k      = int'(TO);
                killed = 1'b1;
            end
            exp_stall = k + 1;
        end
        e.rd = rd;
        if (mis) begin
            e.we   = 1'b0;
            e.data = 64'd0;
        end else if (!acc) begin
            e.we   = rwe;
            e.data = addr;
        end else begin
            e.we   = rwe & ~killed & ~(r & w);
            e.data = m2r ? rdata : addr;
        end
        sb_q.push_back(e);
        if (mis)    exp_mis = 1'b1;
        if (killed) exp_bus = 1'b1;

        mem_read_MEM   = r;
        memWrite_E_MEM = w;
        MemToReg_MEM   = m2r;
        regWrite_E_MEM = rwe;
        ALU_out_MEM    = addr;
        regWrite_MEM   = rd;
        mem_Din_MEM    = din;

        n_stall = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            dmem_ack   = acc && !mis && (ack_at >= 1) && (cyc == ack_at);
            dmem_rdata = rdata;
            @(negedge clk);
            stl = stall_MEM;
            if (stl) n_stall++;
            if (acc && !mis && cyc >= 1 && cyc <= k) begin
                check_eq({tag, "_busy_req"},   64'(dmem_req),   64'd1);
                check_eq({tag, "_busy_we"},    64'(dmem_we),    64'(w));
                check_eq({tag, "_busy_addr"},  dmem_addr,       addr);
                check_eq({tag, "_busy_wdata"}, dmem_wdata,      din);
            end
            if (acc && !mis && cyc >= 1)
                check_eq({tag, "_stall_bubble"}, 64'(regWrite_E_WB), 64'd0);
            if (acc && !mis && cyc == k + 1)
                check_eq({tag, "_done_req"}, 64'(dmem_req), 64'd0);
            if (mis && cyc == 0)
                check_eq({tag, "_mis_req"}, 64'(dmem_req), 64'd0);
            @(posedge clk);
            #1;
            if (!stl) begin
                done = 1'b1;
                break;
            end
        end
        dmem_ack = 1'b0;

        check_eq({tag, "_completed"},    64'(done),    64'd1);
        check_eq({tag, "_stall_cycles"}, 64'(n_stall), 64'(exp_stall));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "_wb_we"}, 64'(regWrite_E_WB), 64'(e.we));
            if (e.we) begin
                check_eq({tag, "_wb_rd"},   64'(regWrite_WB), 64'(e.rd));
                check_eq({tag, "_wb_data"}, wb_data_WB,       e.data);
            end
        end
        check_eq({tag, "_misalign_err"}, 64'(misalign_err), 64'(exp_mis));
        check_eq({tag, "_bus_err"},      64'(bus_err),      64'(exp_bus));
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'd0;
        drive_nop();
        #2;
        check_eq("rst_req",   64'(dmem_req),      64'd0);
        check_eq("rst_we",    64'(dmem_we),       64'd0);
        check_eq("rst_addr",  dmem_addr,          64'd0);
        check_eq("rst_wb_we", 64'(regWrite_E_WB), 64'd0);
        check_eq("rst_wb_rd", 64'(regWrite_WB),   64'd0);
        check_eq("rst_wb_d",  wb_data_WB,         64'd0);
        check_eq("rst_stall", 64'(stall_MEM),     64'd0);
        check_eq("rst_mis",   64'(misalign_err),  64'd0);
        check_eq("rst_bus",   64'(bus_err),       64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //        tag       r     w     m2r   rwe   addr             rd     din         ack  rdata
        run_instr("alu",    1'b0, 1'b0, 1'b0, 1'b1, 64'h1234,        5'd5,  64'd0,      0,   64'd0);
        run_instr("load40", 1'b1, 1'b0, 1'b1, 1'b1, 64'h40,          5'd7,  64'h5555,   3,   64'hDEADBEEF);
        run_instr("st88",   1'b0, 1'b1, 1'b0, 1'b0, 64'h88,          5'd0,  64'hAA,     1,   64'h0);
        run_instr("ld43",   1'b1, 1'b0, 1'b1, 1'b1, 64'h43,          5'd8,  64'd0,      1,   64'h1111);
        run_instr("alu2",   1'b0, 1'b0, 1'b0, 1'b1, 64'hCAFE_0000,   5'd9,  64'd0,      0,   64'd0);
        run_instr("tmo",    1'b1, 1'b0, 1'b1, 1'b1, 64'h100,         5'd10, 64'd0,      0,   64'h2222);
        run_instr("ackedge",1'b1, 1'b0, 1'b1, 1'b1, 64'h108,         5'd3,  64'd0,      4,   64'h3333_4444);
        run_instr("acklate",1'b1, 1'b0, 1'b1, 1'b1, 64'h110,         5'd11, 64'd0,      5,   64'h7777);
        run_instr("rw",     1'b1, 1'b1, 1'b1, 1'b1, 64'h118,         5'd13, 64'h99,     2,   64'h8888);
        run_instr("ldalu",  1'b1, 1'b0, 1'b0, 1'b1, 64'h120,         5'd12, 64'd0,      1,   64'h9999);
        run_instr("nowe",   1'b0, 1'b0, 1'b0, 1'b0, 64'h55,          5'd14, 64'd0,      0,   64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [63:0] a;
            logic [63:0] d;
            a = {32'($urandom), 32'($urandom)};
            d = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 0)
                run_instr("rnd_alu", 1'b0, 1'b0, 1'b0, 1'b1, a, 5'($urandom_range(1, 31)), 64'd0, 0, d);
            else
                run_instr("rnd_ld", 1'b1, 1'b0, 1'b1, 1'b1, {a[63:3], 3'b000},
                          5'($urandom_range(1, 31)), 64'd0, int'($urandom_range(1, 3)), d);
        end

        // Reset during the second BUSY cycle of a load.
        run_instr("pre_rst", 1'b0, 1'b0, 1'b0, 1'b1, 64'hABCD, 5'd21, 64'd0, 0, 64'd0);
        mem_read_MEM   = 1'b1;
        MemToReg_MEM   = 1'b1;
        regWrite_E_MEM = 1'b1;
        ALU_out_MEM    = 64'h200;
        regWrite_MEM   = 5'd4;
        mem_Din_MEM    = 64'h77;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("mid_req_before", 64'(dmem_req), 64'd1);
        reset = 1'b1;
        drive_nop();
        #1;
        check_eq("mid_req",   64'(dmem_req),      64'd0);
        check_eq("mid_we",    64'(dmem_we),       64'd0);
        check_eq("mid_addr",  dmem_addr,          64'd0);
        check_eq("mid_wdata", dmem_wdata,         64'd0);
        check_eq("mid_wb_we", 64'(regWrite_E_WB), 64'd0);
        check_eq("mid_wb_rd", 64'(regWrite_WB),   64'd0);
        check_eq("mid_wb_d",  wb_data_WB,         64'd0);
        check_eq("mid_mis",   64'(misalign_err),  64'd0);
        check_eq("mid_bus",   64'(bus_err),       64'd0);
        check_eq("mid_stall", 64'(stall_MEM),     64'd0);
        exp_mis = 1'b0;
        exp_bus = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD0;
        @(negedge clk);
        check_eq("late_ack_req",   64'(dmem_req),  64'd0);
        check_eq("late_ack_stall", 64'(stall_MEM), 64'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check_eq("late_ack_wb_we", 64'(regWrite_E_WB), 64'd0);
        check_eq("late_ack_wb_d",  wb_data_WB,         64'd0);
        run_instr("post_rst", 1'b1, 1'b0, 1'b1, 1'b1, 64'h300, 5'd6, 64'd0, 2, 64'h1357);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
